// File: rtl/fifo_ctrl_pkg.sv
// rtl/fifo_ctrl_pkg.sv - shared constants and occupancy-update helper for fifo_ctrl
package fifo_ctrl_pkg;

  // Address width of the downstream register_file; fixed by its 32-entry depth.
  localparam int STORE_AW = 5;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  function automatic cnt_op_e cnt_op(input logic push_ok, input logic pop_ok);
    cnt_op_e op;
    op = CNT_HOLD;
    if (push_ok && !pop_ok) begin
      op = CNT_INC;
    end else if (pop_ok && !push_ok) begin
      op = CNT_DEC;
    end
    return op;
  endfunction

endpackage

// File: rtl/fifo_ctrl_edge_pulse.sv
// rtl/fifo_ctrl_edge_pulse.sv - rising-edge detector: one-cycle pulse per low-to-high transition
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_pulse
);

  logic r_hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= 1'b0;
    end else begin
      r_hist <= i_level;
    end
  end

  assign o_pulse = i_level & ~r_hist;

endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - circular FIFO controller driving an external register_file
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enq,
  input  logic                deq,
  input  logic [WIDTH-1:0]    in,
  output logic [WIDTH-1:0]    out,
  output logic                full,
  output logic                empty,
  output logic [AW:0]         count,
  output logic                ovf,
  output logic                udf,
  output logic [STORE_AW-1:0] ra0,
  input  logic [WIDTH-1:0]    rd0,
  output logic [STORE_AW-1:0] wa,
  output logic                we,
  output logic [WIDTH-1:0]    wd
);

  localparam int DEPTH = 1 << AW;

  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_out;
  logic             r_ovf;
  logic             r_udf;

  logic    w_enq_p;
  logic    w_deq_p;
  logic    w_full;
  logic    w_empty;
  logic    w_push_ok;
  logic    w_pop_ok;
  cnt_op_e w_cnt_op;

  edge_pulse u_enq_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (enq),
    .o_pulse (w_enq_p)
  );

  edge_pulse u_deq_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (deq),
    .o_pulse (w_deq_p)
  );

  // Status comes straight from the count register; a same-cycle push does not make the queue non-empty.
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push_ok = w_enq_p & ~w_full;
  assign w_pop_ok  = w_deq_p & ~w_empty;
  assign w_cnt_op  = cnt_op(w_push_ok, w_pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_out   <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_tail <= r_tail + AW'(1);
      end
      if (w_pop_ok) begin
        r_head <= r_head + AW'(1);
        r_out  <= rd0;
      end
      case (w_cnt_op)
        CNT_INC: r_count <= r_count + (AW+1)'(1);
        CNT_DEC: r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      r_ovf <= w_enq_p & w_full;
      r_udf <= w_deq_p & w_empty;
    end
  end

  assign ra0   = STORE_AW'(r_head);
  assign wa    = STORE_AW'(r_tail);
  assign wd    = in;
  assign we    = w_push_ok & ~rst;
  assign out   = r_out;
  assign full  = w_full;
  assign empty = w_empty;
  assign count = r_count;
  assign ovf   = r_ovf;
  assign udf   = r_udf;

endmodule
